// File: rtl/pic_mem_pkg.sv
// Shared definitions for the pic_mem upstream loader.
// Holds the loader state encoding, the default pic_mem s2 geometry and the
// RGB565 pixel word type.
package pic_mem_pkg;

    localparam int unsigned PIC_ADDR_W      = 12;
    localparam int unsigned PIC_FRAME_WORDS = 2048;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DONE
    } loader_state_t;

    typedef logic [15:0] rgb565_t;

endpackage

// File: rtl/pic_mem_loader_if.sv
// Bus bundles for pic_mem_loader.
// pic_stream_if : byte stream (s_data, s_valid, s_sof in; s_ready back).
//                 master = byte source, slave = loader.
// pic_mem_s2_if : pic_mem s2 write port (address, chipselect, clken, write,
//                 writedata, byteenable). master = loader, slave = memory.
interface pic_stream_if;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_sof;
    logic       s_ready;

    modport master (output s_data, output s_valid, output s_sof, input  s_ready);
    modport slave  (input  s_data, input  s_valid, input  s_sof, output s_ready);
endinterface

interface pic_mem_s2_if #(
    parameter int unsigned ADDR_W = 12
);
    logic [ADDR_W-1:0] mem_address;
    logic              mem_chipselect;
    logic              mem_clken;
    logic              mem_write;
    logic [15:0]       mem_writedata;
    logic [1:0]        mem_byteenable;

    modport master (output mem_address, output mem_chipselect, output mem_clken,
                    output mem_write, output mem_writedata, output mem_byteenable);
    modport slave  (input  mem_address, input  mem_chipselect, input  mem_clken,
                    input  mem_write, input  mem_writedata, input  mem_byteenable);
endinterface

// File: rtl/pic_mem_loader.sv
// pic_mem_loader: packs a byte stream (high byte first) into RGB565 words and
// writes them into the half of pic_mem that the LCD is not displaying.
// Ports:
//   clk, reset_n  : clock, asynchronous active-low reset
//   buffer_flag   : displayed half (0: lower half shown, so fill upper half)
//   s             : byte stream slave (s_data, s_valid, s_sof, s_ready)
//   mem           : pic_mem s2 write master
//   frame_done    : one-cycle pulse alongside the last write of a frame
//   frame_abort   : one-cycle pulse when s_sof truncates a frame in progress
// All outputs are registered.
module pic_mem_loader
    import pic_mem_pkg::*;
#(
    parameter int unsigned ADDR_W      = PIC_ADDR_W,
    parameter int unsigned FRAME_WORDS = PIC_FRAME_WORDS
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          buffer_flag,
    pic_stream_if.slave   s,
    pic_mem_s2_if.master  mem,
    output logic          frame_done,
    output logic          frame_abort
);

    localparam int unsigned       CNT_W      = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
    localparam logic [CNT_W-1:0]  LAST_WORD  = CNT_W'(FRAME_WORDS - 1);
    localparam logic [ADDR_W-1:0] UPPER_BASE = ADDR_W'(FRAME_WORDS);

    loader_state_t     state, state_next;

    logic [7:0]        high_q, high_n;
    logic              phase_q, phase_n;     // 1: high byte held, next byte completes a word
    logic [ADDR_W-1:0] base_q, base_n;
    logic [CNT_W-1:0]  count_q, count_n;
    logic              ready_q, ready_n;
    logic              wr_q, wr_n;
    logic [ADDR_W-1:0] addr_q, addr_n;
    rgb565_t           data_q, data_n;
    logic              done_n, abort_n;

    logic              accept;
    logic              sof_accept;
    logic [ADDR_W-1:0] new_base;

    assign accept     = s.s_valid & ready_q;
    assign sof_accept = accept & s.s_sof;
    // Write into the half the LCD is not reading.
    assign new_base   = buffer_flag ? '0 : UPPER_BASE;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (sof_accept) state_next = ST_LOAD;
            ST_LOAD: if (accept && !s.s_sof && phase_q && count_q == LAST_WORD)
                         state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Output / datapath next values; registered below
    always_comb begin
        high_n  = high_q;
        phase_n = phase_q;
        base_n  = base_q;
        count_n = count_q;
        addr_n  = addr_q;
        data_n  = data_q;
        wr_n    = 1'b0;
        done_n  = 1'b0;
        abort_n = 1'b0;
        // s_ready is registered, so it is derived from where the FSM is heading.
        ready_n = (state_next != ST_DONE);

        case (state)
            ST_IDLE: begin
                if (sof_accept) begin
                    high_n  = s.s_data;
                    base_n  = new_base;
                    count_n = '0;
                    phase_n = 1'b1;
                end
            end
            ST_LOAD: begin
                if (accept) begin
                    if (s.s_sof) begin
                        // Any held high byte is dropped; the sof byte starts afresh.
                        abort_n = 1'b1;
                        high_n  = s.s_data;
                        base_n  = new_base;
                        count_n = '0;
                        phase_n = 1'b1;
                    end else if (!phase_q) begin
                        high_n  = s.s_data;
                        phase_n = 1'b1;
                    end else begin
                        wr_n    = 1'b1;
                        addr_n  = base_q + ADDR_W'(count_q);
                        data_n  = {high_q, s.s_data};
                        count_n = count_q + CNT_W'(1);
                        phase_n = 1'b0;
                        done_n  = (count_q == LAST_WORD);
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            high_q      <= '0;
            phase_q     <= 1'b0;
            base_q      <= '0;
            count_q     <= '0;
            ready_q     <= 1'b0;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            frame_done  <= 1'b0;
            frame_abort <= 1'b0;
        end else begin
            high_q      <= high_n;
            phase_q     <= phase_n;
            base_q      <= base_n;
            count_q     <= count_n;
            ready_q     <= ready_n;
            wr_q        <= wr_n;
            addr_q      <= addr_n;
            data_q      <= data_n;
            frame_done  <= done_n;
            frame_abort <= abort_n;
        end
    end

    assign s.s_ready          = ready_q;
    assign mem.mem_write      = wr_q;
    assign mem.mem_chipselect = wr_q;
    assign mem.mem_address    = addr_q;
    assign mem.mem_writedata  = data_q;
    assign mem.mem_byteenable = 2'b11;
    assign mem.mem_clken      = 1'b1;

endmodule

// File: tb/tb_pic_mem_loader.sv
// Directed self-checking bench for pic_mem_loader.
module tb_pic_mem_loader;

    localparam int unsigned AW = 12;
    localparam int unsigned FW = 2048;

    logic clk = 1'b0;
    logic reset_n;
    logic buffer_flag;
    logic frame_done;
    logic frame_abort;

    int unsigned errors = 0;
    int unsigned checks = 0;
    logic [7:0]  hi;

    pic_stream_if            st ();
    pic_mem_s2_if #(.ADDR_W(AW)) mb ();

    pic_mem_loader #(.ADDR_W(AW), .FRAME_WORDS(FW)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .buffer_flag (buffer_flag),
        .s           (st.slave),
        .mem         (mb.master),
        .frame_done  (frame_done),
        .frame_abort (frame_abort)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one byte, wait (bounded) for s_ready, let it be accepted, and
    // return 1 time unit after the accepting edge.
    task automatic send(input logic [7:0] d, input logic sof);
        int n;
        st.s_data  = d;
        st.s_sof   = sof;
        st.s_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (st.s_ready !== 1'b1 && n < 20) begin
            n++;
            @(negedge clk);
        end
        check("ready_wait", {31'd0, st.s_ready}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    // Send byte k of a frame and check the registered results.
    task automatic frame_byte(input int k, input logic [7:0] d, input logic sof,
                              input logic [AW-1:0] base, input bit gaps);
        int i;
        if (gaps && k > 0 && $urandom_range(0, 1) == 1) begin
            st.s_valid = 1'b0;
            @(posedge clk);
            #1;
            check("gap_ready", {31'd0, st.s_ready}, 32'd1);
            check("gap_write", {31'd0, mb.mem_write}, 32'd0);
        end
        send(d, sof);
        check("abort_idle", {31'd0, frame_abort}, 32'd0);
        if (k % 2 == 0) begin
            hi = d;
            check("hi_write", {31'd0, mb.mem_write}, 32'd0);
            check("hi_ready", {31'd0, st.s_ready}, 32'd1);
        end else begin
            i = k / 2;
            check("wr_strobe", {31'd0, mb.mem_write}, 32'd1);
            check("wr_cs", {31'd0, mb.mem_chipselect}, 32'd1);
            check("wr_addr", 32'(mb.mem_address), 32'(base) + 32'(i));
            check("wr_data", 32'(mb.mem_writedata), {16'd0, hi, d});
            check("wr_done", {31'd0, frame_done}, (i == FW - 1) ? 32'd1 : 32'd0);
            check("wr_ready", {31'd0, st.s_ready}, (i == FW - 1) ? 32'd0 : 32'd1);
        end
    endtask

    task automatic idle_after_frame();
        st.s_valid = 1'b0;
        @(posedge clk);
        #1;
        check("post_ready", {31'd0, st.s_ready}, 32'd1);
        check("post_done", {31'd0, frame_done}, 32'd0);
        check("post_write", {31'd0, mb.mem_write}, 32'd0);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n     = 1'b0;
        buffer_flag = 1'b0;
        st.s_valid  = 1'b0;
        st.s_sof    = 1'b0;
        st.s_data   = 8'h00;
        hi          = 8'h00;

        // Reset values
        #2;
        check("rst_ready", {31'd0, st.s_ready}, 32'd0);
        check("rst_write", {31'd0, mb.mem_write}, 32'd0);
        check("rst_cs", {31'd0, mb.mem_chipselect}, 32'd0);
        check("rst_addr", 32'(mb.mem_address), 32'd0);
        check("rst_data", 32'(mb.mem_writedata), 32'd0);
        check("rst_be", 32'(mb.mem_byteenable), 32'd3);
        check("rst_clken", {31'd0, mb.mem_clken}, 32'd1);
        check("rst_done", {31'd0, frame_done}, 32'd0);
        check("rst_abort", {31'd0, frame_abort}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("rel_ready_low", {31'd0, st.s_ready}, 32'd0);
        @(posedge clk);
        #1;
        check("rel_ready_high", {31'd0, st.s_ready}, 32'd1);

        // Garbage before sof is discarded
        for (int g = 0; g < 5; g++) begin
            send(8'(8'hE0 + g), 1'b0);
            check("garbage_write", {31'd0, mb.mem_write}, 32'd0);
        end

        // Full frame, flag=0 -> upper half
        buffer_flag = 1'b0;
        for (int k = 0; k < 2 * FW; k++)
            frame_byte(k, k[7:0], k == 0, 12'd2048, 1'b0);
        idle_after_frame();

        // Full frame, flag=1 -> lower half; flag flips mid-frame
        buffer_flag = 1'b1;
        for (int k = 0; k < 2 * FW; k++) begin
            if (k == 1000) buffer_flag = 1'b0;
            frame_byte(k, k[7:0], k == 0, 12'd0, 1'b0);
        end
        idle_after_frame();

        // Abort at byte 101, then finish the new frame with backpressure
        buffer_flag = 1'b0;
        for (int k = 0; k <= 100; k++)
            frame_byte(k, k[7:0], k == 0, 12'd2048, 1'b0);
        check("pre_abort_addr", 32'(mb.mem_address), 32'd2048 + 32'd49);
        send(8'hA5, 1'b1);
        hi = 8'hA5;
        check("abort_pulse", {31'd0, frame_abort}, 32'd1);
        check("abort_write", {31'd0, mb.mem_write}, 32'd0);
        check("abort_ready", {31'd0, st.s_ready}, 32'd1);
        for (int k = 1; k < 2 * FW; k++)
            frame_byte(k, (k == 1) ? 8'h3C : k[7:0], 1'b0, 12'd2048, 1'b1);
        idle_after_frame();

        // Reset in the middle of a frame
        buffer_flag = 1'b0;
        for (int k = 0; k < 300; k++)
            frame_byte(k, k[7:0], k == 0, 12'd2048, 1'b0);
        reset_n = 1'b0;
        #1;
        check("midrst_write", {31'd0, mb.mem_write}, 32'd0);
        check("midrst_cs", {31'd0, mb.mem_chipselect}, 32'd0);
        check("midrst_ready", {31'd0, st.s_ready}, 32'd0);
        check("midrst_addr", 32'(mb.mem_address), 32'd0);
        st.s_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_rel_ready", {31'd0, st.s_ready}, 32'd1);
        for (int g = 0; g < 4; g++) begin
            send(8'(8'h50 + g), 1'b0);
            check("post_rst_nowrite", {31'd0, mb.mem_write}, 32'd0);
        end
        buffer_flag = 1'b1;
        for (int k = 0; k < 4; k++)
            frame_byte(k, 8'(8'h90 + k), k == 0, 12'd0, 1'b0);
        st.s_valid = 1'b0;
        @(posedge clk);
        #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pic_mem_loader.md
# pic_mem_loader

Upstream feeder for the SOPC `pic_mem` dual-port RAM (port s2). It accepts a byte stream with a start-of-frame marker and packs byte pairs into 16-bit RGB565 words, high byte first. It writes each word into the half of `pic_mem` that the LCD is not currently displaying, as selected by the SOPC buffer flag. It signals when a complete frame has been committed, so the frame can be handed to the display path.

## Interface

Parameters:
- `ADDR_W`, 12: `pic_mem` s2 address width.
- `FRAME_WORDS`, 2048: words per frame. Must be ≤ 2^(ADDR_W-1).

Ports:
- `clk`, in, 1: system clock. All logic is in this single domain.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `s_data`, in, 8: stream byte.
- `s_valid`, in, 1: byte valid.
- `s_sof`, in, 1: qualifies `s_data` as the first (high) byte of a frame.
- `s_ready`, out, 1: byte accepted when `s_valid & s_ready`.
- `buffer_flag`, in, 1: displayed half. 0 means the LCD reads [0, FRAME_WORDS-1]; 1 means the LCD reads [FRAME_WORDS, 2·FRAME_WORDS-1].
- `mem_address`, out, ADDR_W: s2 address.
- `mem_chipselect`, out, 1: s2 chipselect.
- `mem_clken`, out, 1: s2 clock enable.
- `mem_write`, out, 1: s2 write strobe.
- `mem_writedata`, out, 16: s2 write data.
- `mem_byteenable`, out, 2: s2 byte enables.
- `frame_done`, out, 1: one-cycle pulse when the last word of a frame is written.
- `frame_abort`, out, 1: one-cycle pulse when a new `s_sof` truncates a frame in progress.

## Operation

States: IDLE, LOAD, DONE.

IDLE:
- `s_ready`=1.
- Accepted bytes with `s_sof`=0 are discarded.
- An accepted byte with `s_sof`=1 does the following:
  - stores the byte as the high byte;
  - latches `base = buffer_flag ? 0 : FRAME_WORDS`, sampled on that cycle only;
  - clears `count` and sets `phase`=1;
  - moves to LOAD.

LOAD:
- `s_ready`=1.
- Accepted byte with `phase`=0: stores the high byte, sets `phase`=1.
- Accepted byte with `phase`=1: forms `{high, byte}`. On the next cycle the block issues one write at `base + count`, then `count++` and `phase`=0.
- When the word written is `count == FRAME_WORDS-1`, the block goes to DONE.
- An accepted byte with `s_sof`=1 in LOAD does all of the following:
  - pulses `frame_abort`;
  - cancels any unwritten high byte;
  - re-latches `base` from the current `buffer_flag`;
  - clears `count`;
  - treats the byte as the high byte of a new frame (`phase`=1).
  
  Words already written are not rolled back.

DONE:
- Lasts exactly one cycle, then returns to IDLE.
- `s_ready`=0.

Arithmetic and constant outputs:
- `count` is `$clog2(FRAME_WORDS)` bits and never wraps inside a frame.
- `mem_address = base + count`, ADDR_W bits, with no overflow because base + count ≤ 2·FRAME_WORDS-1.
- `mem_byteenable` is constant 2'b11.
- `mem_clken` is constant 1.
- `mem_chipselect` equals `mem_write`.

Fixed behaviour:
- A change of `buffer_flag` during LOAD has no effect on the frame in progress.

Reset values (all outputs, asynchronous):
- `s_ready`=0.
- `mem_write`=0, `mem_chipselect`=0, `mem_address`=0, `mem_writedata`=0.
- `mem_byteenable`=2'b11, `mem_clken`=1.
- `frame_done`=0, `frame_abort`=0.
- State = IDLE.

After reset release, `s_ready` goes to 1 on the first clock edge. A reset during LOAD discards the partial frame and issues no further writes.

## Timing

- All outputs are registered.
- Write latency: the low byte accepted at edge N produces `mem_write`=1 with address and data valid during cycle N+1, for exactly one cycle.
- Sustained throughput: one byte per cycle, one write every two cycles.
- `frame_done` is asserted in the same cycle as the final write.
- `s_ready` is 0 during that final-write cycle (DONE) and returns to 1 on the next cycle.
- `frame_abort` is asserted the cycle after the offending `s_sof` byte is accepted.
- A pending write from the previous low byte still completes in that cycle. The abort only affects bytes that have not yet formed a word.
- The s2 port has no wait-request; every write completes in one cycle.

## Structure

- Shared package `pic_mem_pkg` holds:
  - the state enum `loader_state_t`;
  - `PIC_ADDR_W` = 12;
  - `PIC_FRAME_WORDS` = 2048;
  - the RGB565 word typedef.
- Single flat module, no sub-module. The byte packer and the address counter are simple enough to live inline.

## Test plan

- **Full frame, flag=0:** stream 4096 bytes, the first with `s_sof`, bytes `k` = k mod 256 →
  - 2048 writes at addresses 2048..4095;
  - word i = {(2i) mod 256, (2i+1) mod 256};
  - `frame_done` once, with the write at 4095.
- **Full frame, flag=1:** same stream → writes at 0..2047. Toggling the flag mid-frame does not move any address.
- **Pre-sof garbage:** 5 bytes without `s_sof` in IDLE → no writes. The following `s_sof` frame starts at the base address.
- **Abort:** `s_sof` at byte 101 (a low-byte position) → `frame_abort` pulse. The next write is at base+0 with the new high byte. 50 words were written before the abort.
- **Backpressure:** `s_valid` toggled randomly → write count and data unchanged. `s_ready`=0 only in the DONE cycle.
- **Reset mid-frame:** assert `reset_n`=0 after 300 bytes → `mem_write` deasserts immediately. After release, there are no writes until the next `s_sof`.
